// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared opcodes, widths and constants for the MIPS decode stage
//
// Purpose : common definitions imported by the ID stage and its register file.
// Contents: opcode constants, nop encoding, datapath/address/specifier widths.
// Config  : none (the ID_BRANCH_FWD_EN build option lives in id_pipe_stage.sv).
package mips_pkg;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;
    localparam int REG_AW = 5;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [31:0] INSTR_NOP = 32'h0;

endpackage

// File: rtl/id_pipe_stage_if.sv
// rtl/id_pipe_stage_if.sv - signal bundle between the pipeline and the ID stage
//
// Purpose : groups every non-clock/reset signal of id_pipe_stage.
// Modports: master - surrounding pipeline (drives fetch/EX/MEM/WB inputs)
//           slave  - the ID stage (drives redirect, stall and decoded operands)
// Config  : none; identical in both ID_BRANCH_FWD_EN builds.
interface id_pipe_stage_if #(
    parameter int ADDR_W = mips_pkg::ADDR_W,
    parameter int DATA_W = mips_pkg::DATA_W
);
    // inputs to the ID stage
    logic              en;
    logic [ADDR_W-1:0] pc_plus4;
    logic [DATA_W-1:0] instr;
    logic              mem_read_ex;
    logic              reg_write_ex;
    logic [4:0]        write_reg_ex;
    logic              reg_write_mem;
    logic [4:0]        write_reg_mem;
    logic [DATA_W-1:0] alu_result_mem;
    logic              reg_write_wb;
    logic [4:0]        write_reg_wb;
    logic [DATA_W-1:0] write_data_wb;
    // outputs of the ID stage
    logic [ADDR_W-1:0] branch_address;
    logic [ADDR_W-1:0] jump_address;
    logic              branch_taken;
    logic              jump;
    logic              if_en;
    logic              id_bubble;
    logic [ADDR_W-1:0] pc_plus4_id;
    logic [DATA_W-1:0] instr_id;
    logic [DATA_W-1:0] reg1;
    logic [DATA_W-1:0] reg2;
    logic [DATA_W-1:0] imm_value;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        rd;
    logic [5:0]        opcode;
    logic [5:0]        funct;

    modport master (
        output en, pc_plus4, instr, mem_read_ex, reg_write_ex, write_reg_ex,
               reg_write_mem, write_reg_mem, alu_result_mem,
               reg_write_wb, write_reg_wb, write_data_wb,
        input  branch_address, jump_address, branch_taken, jump, if_en, id_bubble,
               pc_plus4_id, instr_id, reg1, reg2, imm_value, rs, rt, rd, opcode, funct
    );

    modport slave (
        input  en, pc_plus4, instr, mem_read_ex, reg_write_ex, write_reg_ex,
               reg_write_mem, write_reg_mem, alu_result_mem,
               reg_write_wb, write_reg_wb, write_data_wb,
        output branch_address, jump_address, branch_taken, jump, if_en, id_bubble,
               pc_plus4_id, instr_id, reg1, reg2, imm_value, rs, rt, rd, opcode, funct
    );

endinterface

// File: rtl/register_file.sv
// rtl/register_file.sv - 2-read/1-write register file with write-through reads
//
// Purpose : architectural registers; r0 is hard-wired to zero.
// Ports   : clk, reset (sync, active-high, clears every register)
//           raddr1_i/raddr2_i -> rdata1_o/rdata2_o (combinational)
//           we_i, waddr_i, wdata_i (written on the rising edge when waddr_i != 0)
module register_file
    import mips_pkg::*;
#(
    parameter int DATA_W = mips_pkg::DATA_W,
    parameter int NREG   = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] raddr1_i,
    input  logic [REG_AW-1:0] raddr2_i,
    output logic [DATA_W-1:0] rdata1_o,
    output logic [DATA_W-1:0] rdata2_o,
    input  logic              we_i,
    input  logic [REG_AW-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i
);

    logic [DATA_W-1:0] regs_q [NREG];
    logic              wr_valid;

    assign wr_valid = we_i && (waddr_i != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_valid) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    // Write-through lets WB and ID share a cycle without a separate bypass path.
    always_comb begin
        rdata1_o = regs_q[raddr1_i];
        if (raddr1_i == '0) begin
            rdata1_o = '0;
        end else if (wr_valid && (waddr_i == raddr1_i)) begin
            rdata1_o = wdata_i;
        end
    end

    always_comb begin
        rdata2_o = regs_q[raddr2_i];
        if (raddr2_i == '0) begin
            rdata2_o = '0;
        end else if (wr_valid && (waddr_i == raddr2_i)) begin
            rdata2_o = wdata_i;
        end
    end

endmodule

// File: rtl/id_pipe_stage.sv
// rtl/id_pipe_stage.sv - MIPS decode stage: IF/ID register, register file, beq resolve, hazards
//
// Purpose : holds the IF/ID register, reads operands, resolves beq/j in ID,
//           detects load-use and branch-operand hazards and stalls fetch.
// Ports   : clk, reset (sync, active-high)
//           bus (id_pipe_stage_if.slave): fetch inputs, EX/MEM/WB hazard and
//           writeback inputs; redirect, stall and decoded-operand outputs.
// Config  : ID_BRANCH_FWD_EN - when defined, beq compares use alu_result_mem
//           for a matching MEM-stage producer instead of stalling on it.
module id_pipe_stage #(
    parameter int ADDR_W = mips_pkg::ADDR_W,
    parameter int DATA_W = mips_pkg::DATA_W,
    parameter int NREG   = 32
) (
    input  logic             clk,
    input  logic             reset,
    id_pipe_stage_if.slave   bus
);
    import mips_pkg::*;

    logic [DATA_W-1:0] instr_id_q, instr_id_d;
    logic [ADDR_W-1:0] pc_plus4_id_q, pc_plus4_id_d;

    logic [4:0]        rs_w, rt_w;
    logic [5:0]        opcode_w;
    logic [DATA_W-1:0] reg1_w, reg2_w, imm_w;
    logic [DATA_W-1:0] cmp_a, cmp_b;
    logic              is_beq, is_j;
    logic              ex_match, mem_match;
    logic              load_use, branch_hazard, stall;
    logic              branch_taken_w, jump_w;

    assign opcode_w = instr_id_q[31:26];
    assign rs_w     = instr_id_q[25:21];
    assign rt_w     = instr_id_q[20:16];
    assign imm_w    = {{(DATA_W-16){instr_id_q[15]}}, instr_id_q[15:0]};
    assign is_beq   = (opcode_w == OP_BEQ);
    assign is_j     = (opcode_w == OP_J);

    register_file #(
        .DATA_W (DATA_W),
        .NREG   (NREG)
    ) u_register_file (
        .clk      (clk),
        .reset    (reset),
        .raddr1_i (rs_w),
        .raddr2_i (rt_w),
        .rdata1_o (reg1_w),
        .rdata2_o (reg2_w),
        .we_i     (bus.reg_write_wb),
        .waddr_i  (bus.write_reg_wb),
        .wdata_i  (bus.write_data_wb)
    );

    // A nonzero destination in EX/MEM that matches either source specifier.
    assign ex_match  = (bus.write_reg_ex != '0) &&
                       ((bus.write_reg_ex == rs_w) || (bus.write_reg_ex == rt_w));
    assign mem_match = (bus.write_reg_mem != '0) &&
                       ((bus.write_reg_mem == rs_w) || (bus.write_reg_mem == rt_w));

    assign load_use = bus.mem_read_ex && ex_match;

`ifdef ID_BRANCH_FWD_EN
    logic fwd_a, fwd_b;
    assign fwd_a = bus.reg_write_mem && (bus.write_reg_mem != '0) && (bus.write_reg_mem == rs_w);
    assign fwd_b = bus.reg_write_mem && (bus.write_reg_mem != '0) && (bus.write_reg_mem == rt_w);
    assign cmp_a = fwd_a ? bus.alu_result_mem : reg1_w;
    assign cmp_b = fwd_b ? bus.alu_result_mem : reg2_w;
    assign branch_hazard = is_beq && bus.reg_write_ex && ex_match;
    logic unused_mem_match;
    assign unused_mem_match = mem_match;
`else
    // Without the MEM bypass the beq waits one extra cycle for the value to reach WB.
    assign cmp_a = reg1_w;
    assign cmp_b = reg2_w;
    assign branch_hazard = is_beq && ((bus.reg_write_ex && ex_match) ||
                                      (bus.reg_write_mem && mem_match));
    logic unused_alu_result;
    assign unused_alu_result = ^bus.alu_result_mem;
`endif

    assign stall          = load_use || branch_hazard;
    assign branch_taken_w = is_beq && (cmp_a == cmp_b) && !stall;
    assign jump_w         = is_j && !stall;

    // IF/ID next state: hold on en=0 or stall, flush the wrong-path fetch on redirect.
    always_comb begin
        instr_id_d    = instr_id_q;
        pc_plus4_id_d = pc_plus4_id_q;
        if (bus.en && !stall) begin
            if (branch_taken_w || jump_w) begin
                instr_id_d    = INSTR_NOP;
                pc_plus4_id_d = '0;
            end else begin
                instr_id_d    = bus.instr;
                pc_plus4_id_d = bus.pc_plus4;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            instr_id_q    <= INSTR_NOP;
            pc_plus4_id_q <= '0;
        end else begin
            instr_id_q    <= instr_id_d;
            pc_plus4_id_q <= pc_plus4_id_d;
        end
    end

    assign bus.branch_address = pc_plus4_id_q + {imm_w[ADDR_W-3:0], 2'b00};
    assign bus.jump_address   = {instr_id_q[ADDR_W-3:0], 2'b00};
    assign bus.branch_taken   = branch_taken_w;
    assign bus.jump           = jump_w;
    assign bus.if_en          = !stall;
    assign bus.id_bubble      = stall;
    assign bus.pc_plus4_id    = pc_plus4_id_q;
    assign bus.instr_id       = instr_id_q;
    assign bus.reg1           = reg1_w;
    assign bus.reg2           = reg2_w;
    assign bus.imm_value      = imm_w;
    assign bus.rs             = rs_w;
    assign bus.rt             = rt_w;
    assign bus.rd             = instr_id_q[15:11];
    assign bus.opcode         = opcode_w;
    assign bus.funct          = instr_id_q[5:0];

endmodule

// File: tb/tb_id_pipe_stage.sv
// tb/tb_id_pipe_stage.sv - self-checking bench for id_pipe_stage
module tb_id_pipe_stage;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    id_pipe_stage_if #(.ADDR_W(10), .DATA_W(32)) bus ();

    id_pipe_stage dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // reference state: architectural registers and the instruction sitting in ID
    logic [31:0] mrf [32];
    logic [31:0] m_instr = 32'h0;
    int          m_pc    = 0;

    // expectations derived from the reference state and current inputs
    logic [31:0] e_r1, e_r2, e_imm;
    logic        e_stall, e_bt, e_j;
    int          e_ba, e_ja;

    function automatic logic [31:0] rf_read(int a);
        if (a == 0) return 32'h0;
        if (bus.reg_write_wb && int'(bus.write_reg_wb) == a) return bus.write_data_wb;
        return mrf[a];
    endfunction

    task automatic compute();
        int op, s, t, wex, wm;
        logic src_ex, src_mem, beq;
        logic [31:0] ca, cb;
        op  = int'(m_instr >> 26);
        s   = int'((m_instr >> 21) & 32'h1f);
        t   = int'((m_instr >> 16) & 32'h1f);
        wex = int'(bus.write_reg_ex);
        wm  = int'(bus.write_reg_mem);
        e_r1 = rf_read(s);
        e_r2 = rf_read(t);
        beq  = (op == 4);
        src_ex  = (wex != 0) && (wex == s || wex == t);
        src_mem = (wm != 0) && (wm == s || wm == t);
        e_stall = (bus.mem_read_ex && src_ex) || (beq && bus.reg_write_ex && src_ex);
        ca = e_r1;
        cb = e_r2;
`ifdef ID_BRANCH_FWD_EN
        if (bus.reg_write_mem && wm != 0 && wm == s) ca = bus.alu_result_mem;
        if (bus.reg_write_mem && wm != 0 && wm == t) cb = bus.alu_result_mem;
`else
        if (beq && bus.reg_write_mem && src_mem) e_stall = 1'b1;
`endif
        e_bt  = beq && (ca == cb) && !e_stall;
        e_j   = (op == 2) && !e_stall;
        e_imm = m_instr[15] ? (32'hFFFF0000 | (m_instr & 32'hFFFF)) : (m_instr & 32'hFFFF);
        e_ba  = (m_pc + 4 * int'(m_instr & 32'hFF)) % 1024;
        e_ja  = 4 * int'(m_instr & 32'hFF);
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        compute();
        chk("instr_id",       bus.instr_id,              m_instr);
        chk("pc_plus4_id",    32'(bus.pc_plus4_id),      32'(m_pc));
        chk("reg1",           bus.reg1,                  e_r1);
        chk("reg2",           bus.reg2,                  e_r2);
        chk("imm_value",      bus.imm_value,             e_imm);
        chk("branch_taken",   32'(bus.branch_taken),     32'(e_bt));
        chk("jump",           32'(bus.jump),             32'(e_j));
        chk("if_en",          32'(bus.if_en),            32'(!e_stall));
        chk("id_bubble",      32'(bus.id_bubble),        32'(e_stall));
        chk("branch_address", 32'(bus.branch_address),   32'(e_ba));
        chk("jump_address",   32'(bus.jump_address),     32'(e_ja));
        chk("rs",             32'(bus.rs),               (m_instr >> 21) & 32'h1f);
        chk("rt",             32'(bus.rt),               (m_instr >> 16) & 32'h1f);
        chk("rd",             32'(bus.rd),               (m_instr >> 11) & 32'h1f);
        chk("opcode",         32'(bus.opcode),           m_instr >> 26);
        chk("funct",          32'(bus.funct),            m_instr & 32'h3f);
    endtask

    // advance one clock, updating the reference with the rules for IF/ID and the register file
    task automatic cycle();
        compute();
        @(posedge clk);
        if (reset) begin
            m_instr = 32'h0;
            m_pc    = 0;
            for (int i = 0; i < 32; i++) mrf[i] = 32'h0;
        end else begin
            if (bus.reg_write_wb && bus.write_reg_wb != 0) mrf[bus.write_reg_wb] = bus.write_data_wb;
            if (bus.en && !e_stall) begin
                if (e_bt || e_j) begin
                    m_instr = 32'h0;
                    m_pc    = 0;
                end else begin
                    m_instr = bus.instr;
                    m_pc    = int'(bus.pc_plus4);
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic step();
        #1;
        check_all();
        cycle();
    endtask

    task automatic idle();
        bus.en             = 1'b1;
        bus.mem_read_ex    = 1'b0;
        bus.reg_write_ex   = 1'b0;
        bus.write_reg_ex   = 5'd0;
        bus.reg_write_mem  = 1'b0;
        bus.write_reg_mem  = 5'd0;
        bus.alu_result_mem = 32'h0;
        bus.reg_write_wb   = 1'b0;
        bus.write_reg_wb   = 5'd0;
        bus.write_data_wb  = 32'h0;
    endtask

    task automatic fetch(logic [31:0] ins, logic [9:0] pc);
        bus.instr    = ins;
        bus.pc_plus4 = pc;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mrf[i] = 32'h0;
        idle();
        reset = 1'b1;
        fetch(32'h8C010004, 10'h004);
        @(negedge clk);
        cycle();
        cycle();
        #1;
        chk("rst_instr_id", bus.instr_id, 32'h0);
        chk("rst_if_en", 32'(bus.if_en), 32'd1);
        chk("rst_branch_taken", 32'(bus.branch_taken), 32'd0);
        chk("rst_jump", 32'(bus.jump), 32'd0);
        chk("rst_reg1", bus.reg1, 32'h0);
        chk("rst_reg2", bus.reg2, 32'h0);
        check_all();
        reset = 1'b0;
        fetch(32'h0, 10'h000);
        step();

        // r1 = r2 = 5 then beq r1,r2,+3
        bus.reg_write_wb = 1'b1; bus.write_reg_wb = 5'd1; bus.write_data_wb = 32'd5;
        step();
        bus.write_reg_wb = 5'd2;
        step();
        idle();
        fetch(32'h10220003, 10'h010);
        step();
        fetch(32'h00000020, 10'h014);
        #1;
        chk("beq_taken", 32'(bus.branch_taken), 32'd1);
        chk("beq_address", 32'(bus.branch_address), 32'h01C);
        step();
        #1;
        chk("beq_flush", bus.instr_id, 32'h0);

        // j 0x25
        fetch(32'h08000025, 10'h018);
        step();
        fetch(32'h00000020, 10'h01C);
        #1;
        chk("j_jump", 32'(bus.jump), 32'd1);
        chk("j_address", 32'(bus.jump_address), 32'h094);
        step();
        #1;
        chk("j_flush", bus.instr_id, 32'h0);

        // load-use: lw r3 in EX, add r4,r3,r3 in ID
        fetch(32'h00632020, 10'h030);
        step();
        fetch(32'h01094820, 10'h034);
        bus.mem_read_ex = 1'b1; bus.reg_write_ex = 1'b1; bus.write_reg_ex = 5'd3;
        #1;
        chk("lu_if_en", 32'(bus.if_en), 32'd0);
        chk("lu_bubble", 32'(bus.id_bubble), 32'd1);
        step();
        #1;
        chk("lu_hold", bus.instr_id, 32'h00632020);
        idle();
        #1;
        chk("lu_release", 32'(bus.if_en), 32'd1);
        step();
        #1;
        chk("lu_advance", bus.instr_id, 32'h01094820);

        // write-through on r7, then a write to r0
        fetch(32'h00E04020, 10'h040);
        step();
        bus.reg_write_wb = 1'b1; bus.write_reg_wb = 5'd7; bus.write_data_wb = 32'hDEAD;
        #1;
        chk("wt_reg1", bus.reg1, 32'hDEAD);
        step();
        idle();
        #1;
        chk("rf_reg1", bus.reg1, 32'hDEAD);
        bus.reg_write_wb = 1'b1; bus.write_reg_wb = 5'd0; bus.write_data_wb = 32'hFFFFFFFF;
        #1;
        chk("r0_wt", bus.reg2, 32'h0);
        step();
        idle();
        #1;
        chk("r0_after", bus.reg2, 32'h0);

        // branch target wrap-around: beq r0,r0,+4 at pc_plus4 0x3F8
        fetch(32'h10000004, 10'h3F8);
        step();
        fetch(32'h00000020, 10'h3FC);
        #1;
        chk("wrap_taken", 32'(bus.branch_taken), 32'd1);
        chk("wrap_address", 32'(bus.branch_address), 32'h008);
        step();

        // en=0 freezes IF/ID
        fetch(32'h00632020, 10'h050);
        bus.en = 1'b0;
        step();
        #1;
        chk("en_hold", bus.instr_id, 32'h0);
        bus.en = 1'b1;

        // beq r1,r2 with MEM producing r1=9, rf r2=9
        bus.reg_write_wb = 1'b1; bus.write_reg_wb = 5'd2; bus.write_data_wb = 32'd9;
        fetch(32'h10220003, 10'h020);
        step();
        idle();
        fetch(32'h00000020, 10'h024);
        bus.reg_write_mem = 1'b1; bus.write_reg_mem = 5'd1; bus.alu_result_mem = 32'd9;
        #1;
`ifdef ID_BRANCH_FWD_EN
        chk("fwd_taken", 32'(bus.branch_taken), 32'd1);
        chk("fwd_if_en", 32'(bus.if_en), 32'd1);
`else
        chk("mem_stall_taken", 32'(bus.branch_taken), 32'd0);
        chk("mem_stall_if_en", 32'(bus.if_en), 32'd0);
`endif
        step();
        bus.reg_write_mem = 1'b0; bus.write_reg_mem = 5'd0;
        bus.reg_write_wb = 1'b1; bus.write_reg_wb = 5'd1; bus.write_data_wb = 32'd9;
`ifndef ID_BRANCH_FWD_EN
        #1;
        chk("mem_reeval_instr", bus.instr_id, 32'h10220003);
        chk("mem_reeval_taken", 32'(bus.branch_taken), 32'd1);
`endif
        step();
        idle();
        step();

        // randomized traffic against the reference
        for (int n = 0; n < 400; n++) begin
            int op_sel;
            logic [5:0] op;
            op_sel = int'($urandom_range(0, 3));
            op = (op_sel == 0) ? 6'h04 : (op_sel == 1) ? 6'h02 : (op_sel == 2) ? 6'h23 : 6'h00;
            reset = ($urandom_range(0, 49) == 0);
            bus.en = ($urandom_range(0, 7) != 0);
            bus.instr = {op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 16'($urandom)};
            bus.pc_plus4 = 10'($urandom);
            bus.mem_read_ex    = 1'($urandom);
            bus.reg_write_ex   = 1'($urandom);
            bus.write_reg_ex   = 5'($urandom_range(0, 3));
            bus.reg_write_mem  = 1'($urandom);
            bus.write_reg_mem  = 5'($urandom_range(0, 3));
            bus.alu_result_mem = 32'($urandom_range(0, 3));
            bus.reg_write_wb   = 1'($urandom);
            bus.write_reg_wb   = 5'($urandom_range(0, 3));
            bus.write_data_wb  = 32'($urandom_range(0, 3));
            step();
        end
        reset = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
